// File: rtl/rv_multicycle_core.sv
// Multi-cycle reduced RV32I core: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer
// sharing one req/ready memory port for instruction and data traffic.
module rv_multicycle_core #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter int unsigned            NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] a0,
  output logic                  halted,
  output logic                  illegal
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("rv_multicycle_core: DATA_WIDTH must be 32");
  end
  if (NUM_REGS != 16 && NUM_REGS != 32) begin : g_bad_num_regs
    $error("rv_multicycle_core: NUM_REGS must be 16 or 32");
  end

  localparam int unsigned RW = (NUM_REGS == 16) ? 4 : 5;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_ADDI, OP_LUI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_EBREAK, OP_ILL
  } op_t;

  state_t                  state, state_nx;
  logic                    illegal_q, illegal_nx;
  logic [31:0]             ir;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [DATA_WIDTH-1:0]   opa, opb, res;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  op_t                     op;
  logic [DATA_WIDTH-1:0]   imm, alu, sum;
  logic                    use_rs1, use_rs2, use_rd, regs_ok;
  logic [RW-1:0]           rs1, rs2, rd;
  logic                    is_branch, taken, mem_misaligned, br_misaligned;
  logic [ADDR_WIDTH-1:0]   br_target, pc_plus4, maddr;

  function automatic logic idx_bad(input logic [4:0] idx);
    return 32'(idx) >= NUM_REGS;
  endfunction

  assign rs1 = ir[15 +: RW];
  assign rs2 = ir[20 +: RW];
  assign rd  = ir[7 +: RW];

  always_comb begin
    op      = OP_ILL;
    imm     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (ir[6:0])
      7'b0110011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        if (ir[14:12] == 3'd0 && ir[31:25] == 7'h00)      op = OP_ADD;
        else if (ir[14:12] == 3'd0 && ir[31:25] == 7'h20) op = OP_SUB;
      end
      7'b0010011: begin
        use_rs1 = 1'b1; use_rd = 1'b1;
        imm = {{20{ir[31]}}, ir[31:20]};
        if (ir[14:12] == 3'd0) op = OP_ADDI;
      end
      7'b0110111: begin
        use_rd = 1'b1;
        imm = {ir[31:12], 12'h000};
        op  = OP_LUI;
      end
      7'b1100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        if (ir[14:12] == 3'd0)      op = OP_BEQ;
        else if (ir[14:12] == 3'd1) op = OP_BNE;
      end
      7'b0000011: begin
        use_rs1 = 1'b1; use_rd = 1'b1;
        imm = {{20{ir[31]}}, ir[31:20]};
        if (ir[14:12] == 3'd2) op = OP_LW;
      end
      7'b0100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        if (ir[14:12] == 3'd2) op = OP_SW;
      end
      7'b1110011: begin
        if (ir == 32'h0010_0073) op = OP_EBREAK;
      end
      default: ;
    endcase
  end

  assign regs_ok = !((use_rs1 && idx_bad(ir[19:15])) ||
                     (use_rs2 && idx_bad(ir[24:20])) ||
                     (use_rd  && idx_bad(ir[11:7])));

  assign sum = opa + imm;

  always_comb begin
    alu = sum;
    case (op)
      OP_ADD:  alu = opa + opb;
      OP_SUB:  alu = opa - opb;
      OP_LUI:  alu = imm;
      default: alu = sum;
    endcase
  end

  assign is_branch      = (op == OP_BEQ) || (op == OP_BNE);
  assign taken          = (op == OP_BEQ) ? (opa == opb) : (opa != opb);
  assign br_target      = pc + ADDR_WIDTH'($signed(imm));
  assign br_misaligned  = br_target[1:0] != 2'b00;
  assign mem_misaligned = sum[1:0] != 2'b00;
  assign pc_plus4       = pc + ADDR_WIDTH'(4);
  assign maddr          = ADDR_WIDTH'(res);

  always_comb begin
    state_nx   = state;
    illegal_nx = illegal_q;
    case (state)
      S_FETCH: if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        if (op == OP_ILL || !regs_ok) begin
          state_nx   = S_HALT;
          illegal_nx = 1'b1;
        end else if (op == OP_EBREAK) begin
          state_nx = S_HALT;
        end else begin
          state_nx = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_branch) begin
          if (taken && br_misaligned) begin
            state_nx   = S_HALT;
            illegal_nx = 1'b1;
          end else begin
            state_nx = S_FETCH;
          end
        end else if (op == OP_LW || op == OP_SW) begin
          if (mem_misaligned) begin
            state_nx   = S_HALT;
            illegal_nx = 1'b1;
          end else begin
            state_nx = S_MEM;
          end
        end else begin
          state_nx = S_WRITEBACK;
        end
      end
      S_MEM:       if (mem_ready) state_nx = (op == OP_LW) ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK: state_nx = S_FETCH;
      S_HALT:      state_nx = S_HALT;
      default:     state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nx;
      illegal_q <= illegal_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= RESET_PC;
      ir  <= '0;
      opa <= '0;
      opb <= '0;
      res <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) ir <= mem_rdata;
        S_DECODE: begin
          opa <= regs[rs1];
          opb <= regs[rs2];
        end
        S_EXECUTE: begin
          res <= alu;
          // a misaligned taken branch halts with the PC left on the branch
          if (is_branch && state_nx == S_FETCH) pc <= taken ? br_target : pc_plus4;
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op == OP_LW) res <= mem_rdata;
            else             pc  <= pc_plus4;
          end
        end
        S_WRITEBACK: begin
          if (rd != '0) regs[rd] <= res;
          pc <= pc_plus4;
        end
        default: ;
      endcase
    end
  end

  // Bus outputs are gated by rst so they fall without waiting for a clock edge.
  assign mem_req   = !rst && (state == S_FETCH || state == S_MEM);
  assign mem_we    = !rst && (state == S_MEM) && (op == OP_SW);
  assign mem_addr  = rst ? '0 : (state == S_FETCH) ? pc : (state == S_MEM) ? maddr : '0;
  assign mem_wdata = mem_we ? opb : '0;
  assign halted    = (state == S_HALT);
  assign illegal   = illegal_q;
  assign a0        = regs[10];

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Directed bench for rv_multicycle_core: an instruction-level model predicts every
// bus beat and the architectural result, plus hand-computed literal expectations.
module tb_rv_multicycle_core;

  logic        clk, rst;
  logic        mem_req, mem_we, mem_ready, halted, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, a0;

  logic        mem_req16, mem_we16, mem_ready16, halted16, illegal16;
  logic [31:0] mem_addr16, mem_wdata16, mem_rdata16, a0_16;

  rv_multicycle_core #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0), .NUM_REGS(32)
  ) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .a0(a0), .halted(halted), .illegal(illegal)
  );

  rv_multicycle_core #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0), .NUM_REGS(16)
  ) dut16 (
    .clk(clk), .rst(rst), .mem_req(mem_req16), .mem_we(mem_we16), .mem_addr(mem_addr16),
    .mem_wdata(mem_wdata16), .mem_rdata(mem_rdata16), .mem_ready(mem_ready16),
    .a0(a0_16), .halted(halted16), .illegal(illegal16)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] a0;
  } tx_t;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  int          n_vec = 0, n_err = 0;
  int          mem_delay = 0;
  int          n_acc, n_fetch8, n_wecyc;
  logic        check_en = 1'b0;
  logic [31:0] prog  [64];
  logic [31:0] tbmem [64];
  logic [31:0] m_mem [64];
  logic [31:0] m_x   [32];
  logic        m_halted, m_ill;
  tx_t         exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'd0, rd, 7'h13);
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic void wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_x[r] = v;
  endfunction

  // Instruction-set model: executes the program and queues every expected bus beat.
  task automatic iss_run();
    logic [31:0] pc, ins, ii, is, ib, ad, tg;
    logic [6:0]  opc, f7;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic        tk;
    exp_q.delete();
    pc = '0; m_halted = 1'b0; m_ill = 1'b0;
    for (int k = 0; k < 32; k++) m_x[k] = '0;
    for (int s = 0; s < 1000 && !m_halted; s++) begin
      exp_q.push_back(tx_t'{1'b0, pc, 32'h0, m_x[10]});
      ins = m_mem[pc[7:2]];
      opc = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
      r1 = ins[19:15]; r2 = ins[24:20]; f7 = ins[31:25];
      ii = {{20{ins[31]}}, ins[31:20]};
      is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      if (ins == EBREAK) m_halted = 1'b1;
      else if (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h00) begin wr(rd, m_x[r1] + m_x[r2]); pc += 4; end
      else if (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h20) begin wr(rd, m_x[r1] - m_x[r2]); pc += 4; end
      else if (opc == 7'h13 && f3 == 3'd0) begin wr(rd, m_x[r1] + ii); pc += 4; end
      else if (opc == 7'h37) begin wr(rd, {ins[31:12], 12'h000}); pc += 4; end
      else if (opc == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
        tk = (f3 == 3'd0) ? (m_x[r1] == m_x[r2]) : (m_x[r1] != m_x[r2]);
        tg = pc + ib;
        if (!tk) pc += 4;
        else if (tg[1:0] != 2'b00) begin m_halted = 1'b1; m_ill = 1'b1; end
        else pc = tg;
      end
      else if (opc == 7'h03 && f3 == 3'd2) begin
        ad = m_x[r1] + ii;
        if (ad[1:0] != 2'b00) begin m_halted = 1'b1; m_ill = 1'b1; end
        else begin
          exp_q.push_back(tx_t'{1'b0, ad, 32'h0, m_x[10]});
          wr(rd, m_mem[ad[7:2]]);
          pc += 4;
        end
      end
      else if (opc == 7'h23 && f3 == 3'd2) begin
        ad = m_x[r1] + is;
        if (ad[1:0] != 2'b00) begin m_halted = 1'b1; m_ill = 1'b1; end
        else begin
          exp_q.push_back(tx_t'{1'b1, ad, m_x[r2], m_x[10]});
          m_mem[ad[7:2]] = m_x[r2];
          pc += 4;
        end
      end
      else begin m_halted = 1'b1; m_ill = 1'b1; end
    end
  endtask

  // Memory responder: grants each request after mem_delay wait cycles.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (rst || !mem_req) begin
        mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF; cnt = 0;
      end else if (cnt >= mem_delay) begin
        mem_ready = 1'b1;
        mem_rdata = tbmem[mem_addr[7:2]];
        if (mem_we) tbmem[mem_addr[7:2]] = mem_wdata;
        cnt = 0;
      end else begin
        mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF; cnt++;
      end
    end
  end

  // Compare process: every requesting cycle must match the head expected beat.
  initial begin
    tx_t h;
    forever begin
      @(negedge clk);
      if (check_en && !rst && mem_req) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL extra_req: got request at addr %h, required no request", mem_addr);
        end else begin
          h = exp_q[0];
          chk("bus_we", {31'b0, mem_we}, {31'b0, h.we});
          chk("bus_addr", mem_addr, h.addr);
          if (h.we) chk("bus_wdata", mem_wdata, h.wdata);
          chk("a0_during_instr", a0, h.a0);
          if (mem_we) n_wecyc++;
          if (mem_ready) begin
            void'(exp_q.pop_front());
            n_acc++;
            if (!mem_we && mem_addr == 32'd8) n_fetch8++;
          end
        end
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
  endtask

  task automatic start_prog(input int delay);
    check_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 64; i++) begin tbmem[i] = prog[i]; m_mem[i] = prog[i]; end
    iss_run();
    n_acc = 0; n_fetch8 = 0; n_wecyc = 0;
    mem_delay = delay;
    check_en = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic finish_prog();
    for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
    @(negedge clk);
    chk("halted", {31'b0, halted}, 32'd1);
    chk("illegal_vs_model", {31'b0, illegal}, {31'b0, m_ill});
    chk("a0_final_vs_model", a0, m_x[10]);
    chk("beats_left", exp_q.size(), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("req_after_halt", {31'b0, mem_req}, 32'd0);
    end
  endtask

  // Called just after a negedge: raises rst mid-cycle and checks outputs without an edge.
  task automatic async_rst_check();
    check_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_a0", a0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    mem_ready16 = 1'b1;
    mem_rdata16 = addi(5'd20, 5'd0, 12'd1);

    // Reset while a fetch is stalled, then single ADDI latency
    clear_prog();
    prog[0] = 32'h0050_0513;
    start_prog(20);
    repeat (2) @(negedge clk);
    chk("stall_req", {31'b0, mem_req}, 32'd1);
    chk("stall_addr", mem_addr, 32'd0);
    async_rst_check();

    start_prog(0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    chk("first_fetch_addr", mem_addr, 32'd0);
    repeat (3) @(negedge clk);
    chk("addi_a0_cycle3", a0, 32'd0);
    @(negedge clk);
    chk("addi_a0_cycle4", a0, 32'd5);
    chk("addi_next_fetch", mem_addr, 32'd4);
    chk("addi_next_req", {31'b0, mem_req}, 32'd1);
    finish_prog();
    chk("rv32e_halted", {31'b0, halted16}, 32'd1);
    chk("rv32e_illegal", {31'b0, illegal16}, 32'd1);
    chk("rv32e_req", {31'b0, mem_req16}, 32'd0);
    chk("rv32e_a0", a0_16, 32'd0);

    // Counting loop ending in EBREAK
    clear_prog();
    prog[0] = 32'h0000_0513; prog[1] = 32'h0030_0593; prog[2] = 32'h0015_0513;
    prog[3] = 32'hFEB5_1EE3; prog[4] = EBREAK;
    start_prog(1);
    finish_prog();
    chk("loop_a0", a0, 32'd3);
    chk("loop_illegal", {31'b0, illegal}, 32'd0);
    chk("loop_fetch8", n_fetch8, 32'd3);
    async_rst_check();

    // Store then load through a stalled bus
    clear_prog();
    prog[0] = enc_b(13'd16, 5'd0, 5'd0, 3'd0);
    prog[4] = addi(5'd10, 5'd0, 12'd9);
    prog[5] = enc_s(12'd8, 5'd10, 5'd0);
    prog[6] = enc_i(12'd8, 5'd0, 3'd2, 5'd12, 7'h03);
    prog[7] = enc_r(7'h00, 5'd12, 5'd12, 5'd10);
    prog[8] = EBREAK;
    start_prog(3);
    finish_prog();
    chk("sw_lw_a0", a0, 32'd18);
    chk("sw_beat_cycles", n_wecyc, 32'd4);
    chk("sw_mem_word", tbmem[2], 32'd9);

    // Illegal encodings
    clear_prog();
    prog[0] = 32'hFFFF_FFFF;
    start_prog(0);
    finish_prog();
    chk("ill_word_illegal", {31'b0, illegal}, 32'd1);
    async_rst_check();

    clear_prog();
    prog[0] = enc_i(12'd2, 5'd0, 3'd2, 5'd1, 7'h03);
    start_prog(0);
    finish_prog();
    chk("lw_mis_illegal", {31'b0, illegal}, 32'd1);
    chk("lw_mis_beats", n_acc, 32'd1);

    // x0 discard and wrap-around arithmetic
    clear_prog();
    prog[0] = addi(5'd10, 5'd0, 12'd4); prog[1] = addi(5'd0, 5'd0, 12'd7);
    prog[2] = enc_r(7'h00, 5'd0, 5'd0, 5'd10); prog[3] = EBREAK;
    start_prog(0);
    finish_prog();
    chk("x0_a0", a0, 32'd0);

    clear_prog();
    prog[0] = {20'hFFFFF, 5'd10, 7'h37}; prog[1] = addi(5'd10, 5'd10, 12'hFFF);
    prog[2] = EBREAK;
    start_prog(0);
    finish_prog();
    chk("lui_addi_a0", a0, 32'hFFFF_EFFF);

    clear_prog();
    prog[0] = addi(5'd10, 5'd0, 12'hFFF); prog[1] = addi(5'd10, 5'd10, 12'd1);
    prog[2] = EBREAK;
    start_prog(2);
    finish_prog();
    chk("wrap_a0", a0, 32'd0);
    chk("wrap_illegal", {31'b0, illegal}, 32'd0);

    clear_prog();
    prog[0] = addi(5'd11, 5'd0, 12'd3); prog[1] = addi(5'd12, 5'd0, 12'd5);
    prog[2] = enc_r(7'h20, 5'd12, 5'd11, 5'd10); prog[3] = EBREAK;
    start_prog(0);
    finish_prog();
    chk("sub_a0", a0, 32'hFFFF_FFFE);

    // Taken branch to a non-word-aligned target
    clear_prog();
    prog[0] = addi(5'd10, 5'd0, 12'd1); prog[1] = enc_b(13'd6, 5'd0, 5'd0, 3'd0);
    start_prog(0);
    finish_prog();
    chk("br_mis_illegal", {31'b0, illegal}, 32'd1);
    chk("br_mis_a0", a0, 32'd1);
    chk("br_mis_beats", n_acc, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
